// File: rtl/aes_key_schedule_seq_if.sv
// Handshake and round-key read bus for the AES key-expansion engine.
interface aes_key_schedule_seq_if #(
    parameter int KEY_BITS = 128
);
    logic                start;
    logic [KEY_BITS-1:0] key_in;
    logic                busy;
    logic                done;
    logic                key_valid;
    logic [3:0]          rk_rd_idx;
    logic [127:0]        rk_rd_data;

    // Requester side: issues start/key and reads round keys
    modport master (
        output start, key_in, rk_rd_idx,
        input  busy, done, key_valid, rk_rd_data
    );

    // Engine side
    modport slave (
        input  start, key_in, rk_rd_idx,
        output busy, done, key_valid, rk_rd_data
    );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock,
// full schedule held locally and served as 128-bit round keys.

// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_p;
    logic [7:0] w_inv;

    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally
    always_comb begin
        w_p   = i_a;
        w_inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            w_p   = gmul(w_p, w_p);
            w_inv = gmul(w_inv, w_p);
        end
        o_s = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                    ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_schedule_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic clk,
    input  logic rst,
    aes_key_schedule_seq_if.slave bus
);
    localparam int NK    = KEY_BITS / 32;
    localparam int NR    = NK + 6;
    localparam int TOTAL = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(TOTAL - 1);
    localparam logic [2:0] MOD_MAX = 3'(NK - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic {S_IDLE, S_GEN} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_w [0:TOTAL-1];
    logic [5:0]  r_i;       // next word index to write
    logic [2:0]  r_mod;     // r_i % NK, tracked incrementally
    logic [7:0]  r_rcon;    // Rcon[r_i/NK], advanced on each i%NK==0 word
    logic        r_done;
    logic        r_kv;
    logic [127:0] r_rd;

    logic        w_load, w_gen, w_done_nxt, w_kv_nxt;
    logic [31:0] w_prev, w_back, w_sin, w_sout, w_f, w_new;
    logic [5:0]  w_rd_base;

    assign w_prev = r_w[r_i - 6'd1];
    assign w_back = r_w[r_i - NK_W];

    // RotWord only on the Rcon words; the i%8==4 path substitutes unrotated
    assign w_sin = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.i_a(w_sin[8*g +: 8]), .o_s(w_sout[8*g +: 8]));
    end

    // Word transform f(w[i-1])
    always_comb begin
        w_f = w_prev;
        if (r_mod == 3'd0)
            w_f = w_sout ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_mod == 3'd4)
            w_f = w_sout;
    end

    assign w_new = w_back ^ w_f;

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_gen       = 1'b0;
        w_done_nxt  = 1'b0;
        w_kv_nxt    = r_kv;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_kv_nxt    = 1'b0;
                    w_state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                w_gen = 1'b1;
                if (r_i == LAST_W) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_kv_nxt    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= 6'd0;
            r_mod   <= 3'd0;
            r_rcon  <= 8'h01;
            r_done  <= 1'b0;
            r_kv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_kv    <= w_kv_nxt;
            if (w_load) begin
                r_i    <= NK_W;
                r_mod  <= 3'd0;
                r_rcon <= 8'h01;
            end else if (w_gen) begin
                r_i   <= (r_i == LAST_W) ? 6'd0 : r_i + 6'd1;
                r_mod <= (r_mod == MOD_MAX) ? 3'd0 : r_mod + 3'd1;
                if (r_mod == 3'd0)
                    r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            end
        end
    end

    // Schedule storage; not reset, validity is tracked by key_valid
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int k = 0; k < NK; k++)
                r_w[k] <= bus.key_in[KEY_BITS-1-32*k -: 32];
        end else if (w_gen) begin
            r_w[r_i] <= w_new;
        end
    end

    assign w_rd_base = {bus.rk_rd_idx, 2'b00};

    // Registered round-key read port; out-of-range index reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rd <= '0;
        else if (bus.rk_rd_idx <= 4'(NR))
            r_rd <= {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                     r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
        else
            r_rd <= '0;
    end

    assign bus.busy       = (r_state == S_GEN);
    assign bus.done       = r_done;
    assign bus.key_valid  = r_kv;
    assign bus.rk_rd_data = r_rd;
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for the AES key schedule engine at all three key sizes.
module tb_aes_key_schedule_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    aes_key_schedule_seq_if #(.KEY_BITS(128)) b128 ();
    aes_key_schedule_seq_if #(.KEY_BITS(192)) b192 ();
    aes_key_schedule_seq_if #(.KEY_BITS(256)) b256 ();

    aes_key_schedule_seq #(.KEY_BITS(128)) u128 (.clk(clk), .rst(rst), .bus(b128));
    aes_key_schedule_seq #(.KEY_BITS(192)) u192 (.clk(clk), .rst(rst), .bus(b192));
    aes_key_schedule_seq #(.KEY_BITS(256)) u256 (.clk(clk), .rst(rst), .bus(b256));

    localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KALT = 256'hffeeddccbbaa99887766554433221100;
    localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic dn(input int w);
        case (w)
            128:     return b128.done;
            192:     return b192.done;
            256:     return b256.done;
            default: return 1'b0;
        endcase
    endfunction

    // Pulse start for one clock; returns #1 after the accepting edge
    task automatic go(input int w, input logic [255:0] k);
        case (w)
            128: begin b128.key_in = k[127:0]; b128.start = 1'b1; end
            192: begin b192.key_in = k[191:0]; b192.start = 1'b1; end
            default: begin b256.key_in = k; b256.start = 1'b1; end
        endcase
        @(posedge clk); #1;
        b128.start = 1'b0; b192.start = 1'b0; b256.start = 1'b0;
    endtask

    // Counts edges until done is seen; bounded so a stuck DUT still finishes
    task automatic wait_done(input int w, output int n);
        n = 0;
        while (!dn(w) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic rd(input int w, input logic [3:0] idx, output logic [127:0] d);
        b128.rk_rd_idx = idx; b192.rk_rd_idx = idx; b256.rk_rd_idx = idx;
        @(posedge clk); #1;
        case (w)
            128:     d = b128.rk_rd_data;
            192:     d = b192.rk_rd_data;
            default: d = b256.rk_rd_data;
        endcase
    endtask

    initial begin
        int           n;
        int           pulses;
        logic [127:0] d;

        rst = 1'b1;
        b128.start = 1'b0; b192.start = 1'b0; b256.start = 1'b0;
        b128.key_in = '0;  b192.key_in = '0;  b256.key_in = '0;
        b128.rk_rd_idx = '0; b192.rk_rd_idx = '0; b256.rk_rd_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(b128.busy), 128'd0);
        chk("rst_done", 128'(b128.done), 128'd0);
        chk("rst_kv",   128'({b128.key_valid, b192.key_valid, b256.key_valid}), 128'd0);
        chk("rst_rd",   b128.rk_rd_data | b256.rk_rd_data, 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // AES-128 reference run
        go(128, K128);
        chk("gen_busy128", 128'(b128.busy), 128'd1);
        chk("gen_kv128", 128'(b128.key_valid), 128'd0);
        wait_done(128, n);
        chk("lat128", 128'(n), 128'd40);
        chk("kv128", 128'(b128.key_valid), 128'd1);
        @(posedge clk); #1;
        chk("done_pulse128", 128'(b128.done), 128'd0);
        chk("idle_busy128", 128'(b128.busy), 128'd0);
        rd(128, 4'd0, d);  chk("k128_idx0", d, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd(128, 4'd1, d);  chk("k128_idx1", d, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(128, 4'd10, d); chk("k128_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192
        go(192, K192);
        wait_done(192, n);
        chk("lat192", 128'(n), 128'd46);
        rd(192, 4'd0, d);  chk("k192_idx0", d, 128'h8e73b0f7da0e6452c810f32b809079e5);
        rd(192, 4'd12, d); chk("k192_idx12", d, 128'he98ba06f448c773c8ecc720401002202);

        // AES-256, exercises the i%8==4 SubWord path
        go(256, K256);
        wait_done(256, n);
        chk("lat256", 128'(n), 128'd52);
        rd(256, 4'd0, d);  chk("k256_idx0", d, 128'h603deb1015ca71be2b73aef0857d7781);
        rd(256, 4'd1, d);  chk("k256_idx1", d, 128'h1f352c073b6108d72d9810a30914dff4);
        rd(256, 4'd14, d); chk("k256_idx14", d, 128'hfe4890d1e6188d0b046df344706c631e);

        // start with a different key during GEN is ignored
        go(128, K128);
        repeat (9) begin @(posedge clk); #1; end
        b128.key_in = KALT[127:0];
        b128.start  = 1'b1;
        @(posedge clk); #1;
        b128.start  = 1'b0;
        wait_done(128, n);
        chk("lat_ign", 128'(n + 10), 128'd40);
        rd(128, 4'd10, d); chk("ign_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset mid-expansion
        go(128, K128);
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(b128.busy), 128'd0);
        chk("midrst_kv", 128'(b128.key_valid), 128'd0);
        chk("midrst_rd", b128.rk_rd_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (45) begin
            @(posedge clk); #1;
            if (b128.done) pulses++;
        end
        chk("midrst_nodone", 128'(pulses), 128'd0);
        chk("midrst_kv_hold", 128'(b128.key_valid), 128'd0);
        go(128, K128);
        wait_done(128, n);
        chk("lat_restart", 128'(n), 128'd40);

        // Back-to-back: restart in the done cycle
        chk("b2b_kv_done", 128'(b128.key_valid), 128'd1);
        go(128, K128);
        chk("b2b_kv_drop", 128'(b128.key_valid), 128'd0);
        chk("b2b_busy", 128'(b128.busy), 128'd1);
        wait_done(128, n);
        chk("lat_b2b", 128'(n), 128'd40);
        rd(128, 4'd10, d); chk("b2b_idx10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(128, 4'd15, d); chk("oob_idx15", d, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
